// File: rtl/dmm_req_arbiter.sv
// Round-robin arbiter/sequencer that serialises per-requester malloc/free
// requests onto the single dynamic memory manager interface.
module dmm_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_free,
  input  logic [6*NREQ-1:0] req_size,
  input  logic [3*NREQ-1:0] req_reg,
  output logic [NREQ-1:0]   req_done,
  output logic [NREQ-1:0]   req_err,
  output logic              malloc,
  output logic              free,
  output logic [5:0]        requestedmemsize,
  output logic [2:0]        regmips,
  input  logic              mack,
  input  logic              frack,
  output logic              busy,
  output logic [2:0]        owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [2:0]      last_r, last_s;
  logic [2:0]      owner_r, owner_s;
  logic            op_r, op_s;
  logic [7:0]      cnt_r, cnt_s;
  logic            malloc_r, malloc_s;
  logic            free_r, free_s;
  logic [5:0]      memsize_r, memsize_s;
  logic [2:0]      regmips_r, regmips_s;
  logic [NREQ-1:0] done_r, done_s;
  logic [NREQ-1:0] err_r, err_s;
  logic            busy_r, busy_s;

  logic            grant_found_s;
  logic [2:0]      grant_idx_s;
  logic            grant_free_s;
  logic [5:0]      grant_size_s;
  logic [2:0]      grant_reg_s;
  logic            ack_s;

  function automatic logic [NREQ-1:0] onehot_f(input logic [2:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (idx == 3'(i));
    end
    return v;
  endfunction

  // Round-robin search: requesters above last first, then wrap to 0..last.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found_s && req_valid[i] && (3'(i) > last_r)) begin
        grant_found_s = 1'b1;
        grant_idx_s   = 3'(i);
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found_s && req_valid[i] && (3'(i) <= last_r)) begin
        grant_found_s = 1'b1;
        grant_idx_s   = 3'(i);
      end else begin
        grant_idx_s   = grant_idx_s;
      end
    end
  end

  // Select the granted requester's op, size and register fields.
  always_comb begin
    grant_free_s = 1'b0;
    grant_size_s = 6'd0;
    grant_reg_s  = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx_s == 3'(i)) begin
        grant_free_s = req_free[i];
        grant_size_s = req_size[6*i +: 6];
        grant_reg_s  = req_reg[3*i +: 3];
      end else begin
        grant_free_s = grant_free_s;
      end
    end
  end

  assign ack_s = op_r ? frack : mack;

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    last_s    = last_r;
    owner_s   = owner_r;
    op_s      = op_r;
    cnt_s     = cnt_r;
    malloc_s  = 1'b0;
    free_s    = 1'b0;
    memsize_s = memsize_r;
    regmips_s = regmips_r;
    done_s    = '0;
    err_s     = '0;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          last_s  = grant_idx_s;
          owner_s = grant_idx_s;
          op_s    = grant_free_s;
          if (grant_size_s == 6'd0) begin
            err_s   = onehot_f(grant_idx_s);
            state_s = DONE;
          end else begin
            malloc_s  = ~grant_free_s;
            free_s    = grant_free_s;
            memsize_s = grant_size_s;
            regmips_s = grant_reg_s;
            state_s   = ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_s   = 8'd0;
        state_s = WAIT;
      end
      WAIT: begin
        cnt_s = cnt_r + 8'd1;
        // A matching ack takes precedence over a simultaneous timeout.
        if (ack_s) begin
          done_s    = onehot_f(owner_r);
          memsize_s = 6'd0;
          regmips_s = 3'd0;
          state_s   = DONE;
        end else if (cnt_r == 8'(TIMEOUT - 1)) begin
          err_s     = onehot_f(owner_r);
          memsize_s = 6'd0;
          regmips_s = 3'd0;
          state_s   = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      last_r    <= 3'(NREQ - 1);
      owner_r   <= 3'd0;
      op_r      <= 1'b0;
      cnt_r     <= 8'd0;
      malloc_r  <= 1'b0;
      free_r    <= 1'b0;
      memsize_r <= 6'd0;
      regmips_r <= 3'd0;
      done_r    <= '0;
      err_r     <= '0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      last_r    <= last_s;
      owner_r   <= owner_s;
      op_r      <= op_s;
      cnt_r     <= cnt_s;
      malloc_r  <= malloc_s;
      free_r    <= free_s;
      memsize_r <= memsize_s;
      regmips_r <= regmips_s;
      done_r    <= done_s;
      err_r     <= err_s;
      busy_r    <= busy_s;
    end
  end

  assign req_done         = done_r;
  assign req_err          = err_r;
  assign malloc           = malloc_r;
  assign free             = free_r;
  assign requestedmemsize = memsize_r;
  assign regmips          = regmips_r;
  assign busy             = busy_r;
  assign owner            = owner_r;

endmodule

// File: tb/tb_dmm_req_arbiter.sv
// Directed scoreboard bench for dmm_req_arbiter: expected issues and
// responses are queued with the stimulus and popped as the DUT produces them.
module tb_dmm_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_pend;
  logic [3:0]  req_free_t;
  logic [23:0] req_size_t;
  logic [11:0] req_reg_t;
  logic [3:0]  req_done, req_err;
  logic        malloc, free;
  logic [5:0]  requestedmemsize;
  logic [2:0]  regmips;
  logic        mack_m = 1'b0, frack_m = 1'b0, mack_x = 1'b0;
  logic        busy;
  logic [2:0]  owner;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_issue = 0, n_resp = 0;
  int issue_cyc = 0, resp_cyc = 0, req_cyc = 0;
  int mgr_en = 0, mgr_delay = 1;
  int cd = 0;
  bit cd_free = 1'b0;

  logic [13:0] issue_q[$];
  logic [7:0]  resp_q[$];

  dmm_req_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_pend),
    .req_free         (req_free_t),
    .req_size         (req_size_t),
    .req_reg          (req_reg_t),
    .req_done         (req_done),
    .req_err          (req_err),
    .malloc           (malloc),
    .free             (free),
    .requestedmemsize (requestedmemsize),
    .regmips          (regmips),
    .mack             (mack_m | mack_x),
    .frack            (frack_m),
    .busy             (busy),
    .owner            (owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Manager model: acks mgr_delay cycles after seeing malloc/free.
  always @(negedge clk) begin
    mack_m = 1'b0;
    frack_m = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        if (cd_free) frack_m = 1'b1;
        else mack_m = 1'b1;
      end
    end
    if ((malloc || free) && mgr_en != 0) begin
      cd = mgr_delay;
      cd_free = free;
    end
  end

  // Monitor: pop scoreboard on every issue and every done/err pulse.
  always @(negedge clk) begin
    logic [13:0] ei;
    logic [7:0]  er;
    if (malloc || free) begin
      ei = 'x;
      if (issue_q.size() > 0) ei = issue_q.pop_front();
      check("issue", {owner, malloc, free, requestedmemsize, regmips}, ei);
      n_issue++;
      issue_cyc = cyc;
    end
    if ((req_done | req_err) != 4'b0) begin
      er = 'x;
      if (resp_q.size() > 0) er = resp_q.pop_front();
      check("resp", {req_done, req_err}, er);
      n_resp++;
      resp_cyc = cyc;
      req_pend = req_pend & ~(req_done | req_err);
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drive(input int i, input bit f, input int size, input int rg);
    req_free_t[i] = f;
    req_size_t[6*i +: 6] = 6'(size);
    req_reg_t[3*i +: 3] = 3'(rg);
    req_pend[i] = 1'b1;
  endtask

  task automatic exp_issue(input int i, input bit f, input int size, input int rg);
    issue_q.push_back({3'(i), ~f, f, 6'(size), 3'(rg)});
  endtask

  task automatic exp_resp(input int i, input bit err);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    resp_q.push_back(err ? {4'b0000, oh} : {oh, 4'b0000});
  endtask

  task automatic wait_issue(input int target, input string tag);
    for (int k = 0; k < 300 && n_issue < target; k++) tick();
    check(tag, 32'(n_issue >= target), 32'd1);
  endtask

  task automatic wait_resp(input int target, input string tag);
    for (int k = 0; k < 300 && n_resp < target; k++) tick();
    check(tag, 32'(n_resp >= target), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 300; k++) begin
      if (issue_q.size() == 0 && resp_q.size() == 0 && !busy) break;
      tick();
    end
    check(tag, {31'd0, issue_q.size() == 0 && resp_q.size() == 0 && !busy}, 32'd1);
  endtask

  initial begin
    reset = 1'b0;
    req_pend = 4'b0;
    req_free_t = 4'b0;
    req_size_t = 24'd0;
    req_reg_t = 12'd0;
    tick(2);
    check("reset_outputs", {req_done, req_err, malloc, free, requestedmemsize, regmips, busy, owner}, 32'd0);
    reset = 1'b1;
    tick(2);

    // Single malloc, mack two cycles after malloc
    mgr_en = 1; mgr_delay = 2;
    exp_issue(0, 1'b0, 12, 3); exp_resp(0, 1'b0);
    req_cyc = cyc;
    drive(0, 1'b0, 12, 3);
    wait_resp(n_resp + 1, "single_resp");
    check("single_issue_lat", 32'(issue_cyc - req_cyc), 32'd1);
    check("single_done_lat", 32'(resp_cyc - issue_cyc), 32'd3);
    tick();
    check("single_busy_after", {31'd0, busy}, 32'd0);
    wait_idle("single_idle");

    // Zero size from requester 1, then requester 3 served normally
    mgr_delay = 1;
    exp_resp(1, 1'b1);
    exp_issue(3, 1'b0, 20, 5); exp_resp(3, 1'b0);
    req_cyc = cyc;
    drive(1, 1'b0, 0, 2);
    drive(3, 1'b0, 20, 5);
    wait_resp(n_resp + 1, "zero_resp");
    check("zero_err_lat", 32'(resp_cyc - req_cyc), 32'd1);
    wait_idle("zero_idle");

    // Fairness: all four at once, then 0 and 2 again
    for (int i = 0; i < 4; i++) begin
      exp_issue(i, 1'b0, 10 + i, i); exp_resp(i, 1'b0);
    end
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 10 + i, i);
    wait_idle("rr_all_idle");
    exp_issue(0, 1'b0, 40, 6); exp_resp(0, 1'b0);
    exp_issue(2, 1'b0, 41, 7); exp_resp(2, 1'b0);
    drive(0, 1'b0, 40, 6);
    drive(2, 1'b0, 41, 7);
    wait_idle("rr_02_idle");

    // Timeout: free with no frack, stray mack mid-wait
    mgr_en = 0;
    exp_issue(2, 1'b1, 33, 6); exp_resp(2, 1'b1);
    drive(2, 1'b1, 33, 6);
    wait_issue(n_issue + 1, "to_issue");
    tick(5);
    mack_x = 1'b1;
    tick();
    mack_x = 1'b0;
    wait_resp(n_resp + 1, "to_resp");
    check("to_err_lat", 32'(resp_cyc - issue_cyc), 32'd17);
    wait_idle("to_idle");

    // frack lands on the same cycle the counter hits TIMEOUT
    mgr_en = 1; mgr_delay = 16;
    exp_issue(1, 1'b1, 7, 1); exp_resp(1, 1'b0);
    drive(1, 1'b1, 7, 1);
    wait_resp(n_resp + 1, "coll_resp");
    check("coll_done_lat", 32'(resp_cyc - issue_cyc), 32'd17);
    wait_idle("coll_idle");

    // Reset during WAIT, then 0 has priority over pending 3
    mgr_en = 0;
    exp_issue(1, 1'b0, 9, 4);
    drive(1, 1'b0, 9, 4);
    wait_issue(n_issue + 1, "rst_issue");
    tick(3);
    reset = 1'b0;
    #1;
    check("rst_async_outputs", {req_done, req_err, malloc, free, requestedmemsize, regmips, busy, owner}, 32'd0);
    req_pend = 4'b0;
    resp_q.delete();
    tick(2);
    reset = 1'b1;
    mgr_en = 1; mgr_delay = 1;
    exp_issue(0, 1'b0, 5, 2); exp_resp(0, 1'b0);
    exp_issue(3, 1'b0, 6, 7); exp_resp(3, 1'b0);
    drive(0, 1'b0, 5, 2);
    drive(3, 1'b0, 6, 7);
    wait_idle("post_rst_idle");
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
